wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage MIPS pipeline. It registers the instruction leaving the memory stage, selects and formats the result, and drives the register-file write port of the decode stage. The same write port also serves as the decode stage's W-level internal forward. The block also presents the retiring PC and keeps a retired-instruction counter for trace comparison.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.

- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `M_instr` in 32: instruction leaving the memory stage. An all-zero value is a bubble.
- `M_pc` in 32: PC of `M_instr`.
- `M_alu` in 32: ALU result. For loads, this is the effective address.
- `M_rdata` in 32: aligned data-memory word read at `M_alu[31:2]`.
- `ID_we` out 1: register-file write enable.
- `ID_addr` out 5: destination register.
- `ID_data` out 32: write data.
- `WB_pc_ID` out 32: PC of the instruction currently in write-back.
- `W_instr` out 32: instruction currently in write-back, for the hazard unit.
- `retire_cnt` out RETIRE_W: count of non-bubble instructions retired.

## Operation
- **Pipeline register.** Holds `instr`, `pc`, `alu` and `rdata`.
  - Loaded from the M inputs on every rising edge.
  - There is no stall and no enable. Upstream bubbles arrive as zero instr and zero pc.
- **Destination decode** (opcode = instr[31:26], func = instr[5:0]):
  - opcode 000000, func ≠ 001000 (jr): dest = instr[15:11] (rd), data = alu.
  - addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110, lui 001111: dest = instr[20:16] (rt), data = alu.
  - Loads lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101: dest = rt, data = formatted load (see below).
  - jal 000011: dest = 31, data = pc + 8, modulo 2^32.
  - Anything else (stores, beq, bne, jr, unknown opcodes): no write.
- **Write enable.** `ID_we` = 1 only when the instruction writes and dest ≠ 0.
  - When `ID_we` = 0, `ID_addr` and `ID_data` are driven 0.
  - Consequence: a bubble (sll $0) never asserts `ID_we`.
- **Load formatting.** off = alu[1:0].
  - lw: rdata, offset ignored.
  - lb / lbu: byte rdata[8·off+7 : 8·off], sign-extended / zero-extended.
  - lh / lhu: half = off[1] ? rdata[31:16] : rdata[15:0], sign-extended / zero-extended. off[0] is ignored; misalignment is not trapped.
- **Retire counter.**
  - Increments by 1 on each rising edge at which the registered instr ≠ 0.
  - Wraps from 2^RETIRE_W − 1 to 0.
- **Decode placement.** Decode and formatting may be done before or after the register, provided the output timing below is unchanged.

## Timing
- **Reset.** While `rst` = 0, independent of `clk`, all registers are 0. Resulting outputs:
  - `ID_we` = 0, `ID_addr` = 0, `ID_data` = 0.
  - `WB_pc_ID` = 0, `W_instr` = 0, `retire_cnt` = 0.
- **Reset release.** The first edge after `rst` rises loads the M inputs normally.
- **Reset mid-operation.** The instruction in write-back is discarded. No write is issued and it is not counted.
- **Latency.**
  - An instruction present on the M inputs during cycle n drives the write port throughout cycle n+1.
  - The register file captures it at the edge ending cycle n+1.
  - The decode stage sees it as an internal forward during cycle n+1.
- **Output stability.** Outputs are functions of registered state only; there is no combinational path from the M inputs. Outputs are stable for the whole cycle.
- **Back-to-back writes to the same register.** Each drives the port for exactly one cycle, in program order.
- **Counter timing.** `retire_cnt` reflects instructions that have left write-back. The count for the instruction in W appears in the cycle after it leaves.

## Test plan
- **Reset.** Assert `rst` = 0 mid-stream with `M_instr` = addiu → all outputs 0 immediately. Release: the next edge loads normally and `retire_cnt` stays 0 until a non-bubble instruction retires.
- **R-type / I-type / jal.**
  - Input addu $3 with alu = 0x12345678 → next cycle `ID_we` = 1, `ID_addr` = 3, `ID_data` = 0x12345678.
  - Input ori $5 → `ID_addr` = 5.
  - Input jal at pc 0x00003000 → `ID_addr` = 31, `ID_data` = 0x00003008.
- **Loads.** Use rdata = 0x80FF7F01.
  - lb off 0 → 0x00000001; lb off 2 → 0xFFFFFFFF.
  - lbu off 3 → 0x00000080.
  - lh off 2 → 0xFFFF80FF; lhu off 0 → 0x00007F01.
  - lw → 0x80FF7F01.
- **No-write cases.** sw, beq, jr, bubble (0), and addiu $0 → `ID_we` = 0, `ID_addr` = 0, `ID_data` = 0, with `WB_pc_ID` tracking pc.
- **Counter.**
  - 10 instructions interleaved with 3 bubbles → `retire_cnt` = 10.
  - With RETIRE_W = 4: preload 15 retirements, then one more → 0.
- **Back-to-back.** addiu $2 = 1 followed by addiu $2 = 2 on consecutive cycles → port shows (2, 1) then (2, 2), one cycle each.

Source files
------------

// File: rtl/wb_stage_if.sv
// Memory-stage to write-back bundle plus the decode-stage register-file write port.
// The master drives the M-level signals and the slave is the write-back stage.
interface wb_stage_if;
    logic [31:0] M_instr;
    logic [31:0] M_pc;
    logic [31:0] M_alu;
    logic [31:0] M_rdata;
    logic        ID_we;
    logic [4:0]  ID_addr;
    logic [31:0] ID_data;
    logic [31:0] WB_pc_ID;
    logic [31:0] W_instr;

    modport master (
        output M_instr, M_pc, M_alu, M_rdata,
        input  ID_we, ID_addr, ID_data, WB_pc_ID, W_instr
    );

    modport slave (
        input  M_instr, M_pc, M_alu, M_rdata,
        output ID_we, ID_addr, ID_data, WB_pc_ID, W_instr
    );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: registers the M-stage instruction, decodes its destination,
// formats load data, drives the register-file write port and counts retirements.
module wb_stage #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    wb_stage_if.slave           bus,
    output logic [RETIRE_W-1:0] retire_cnt
);
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr      <= '0;
            pc         <= '0;
            alu        <= '0;
            rdata      <= '0;
            retire_cnt <= '0;
        end else begin
            instr <= bus.M_instr;
            pc    <= bus.M_pc;
            alu   <= bus.M_alu;
            rdata <= bus.M_rdata;
            // Counts the instruction leaving write-back at this edge.
            if (instr != '0)
                retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
    end

    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        writes;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        we;

    assign opcode = instr[31:26];
    assign func   = instr[5:0];
    assign off    = alu[1:0];

    always_comb begin
        ld_byte = rdata[7:0];
        case (off)
            2'd0: ld_byte = rdata[7:0];
            2'd1: ld_byte = rdata[15:8];
            2'd2: ld_byte = rdata[23:16];
            2'd3: ld_byte = rdata[31:24];
            default: ld_byte = rdata[7:0];
        endcase
        ld_half = off[1] ? rdata[31:16] : rdata[15:0];

        ld_data = rdata;
        case (opcode)
            6'b100000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            6'b100100: ld_data = {24'd0, ld_byte};
            6'b100001: ld_data = {{16{ld_half[15]}}, ld_half};
            6'b100101: ld_data = {16'd0, ld_half};
            default:   ld_data = rdata;
        endcase
    end

    always_comb begin
        writes = 1'b0;
        dest   = '0;
        result = '0;
        case (opcode)
            6'b000000: begin
                if (func != 6'b001000) begin
                    writes = 1'b1;
                    dest   = instr[15:11];
                    result = alu;
                end
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                writes = 1'b1;
                dest   = instr[20:16];
                result = alu;
            end
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
                writes = 1'b1;
                dest   = instr[20:16];
                result = ld_data;
            end
            6'b000011: begin
                writes = 1'b1;
                dest   = 5'd31;
                result = pc + 32'd8;
            end
            default: begin
                writes = 1'b0;
            end
        endcase
    end

    // Writes to $0 are suppressed, which also keeps bubbles (sll $0) off the port.
    assign we           = writes && (dest != 5'd0);
    assign bus.ID_we    = we;
    assign bus.ID_addr  = we ? dest : '0;
    assign bus.ID_data  = we ? result : '0;
    assign bus.WB_pc_ID = pc;
    assign bus.W_instr  = instr;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, destination decode, load formatting,
// suppressed writes, back-to-back writes and retire-counter wrap.
module tb_wb_stage;
    logic       clk;
    logic       rst;
    logic       rst4;
    logic [31:0] cnt;
    logic [3:0]  cnt4;

    int unsigned n_checks;
    int unsigned n_fail;

    wb_stage_if bus ();
    wb_stage_if bus4 ();

    wb_stage #(.RETIRE_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .retire_cnt (cnt)
    );

    wb_stage #(.RETIRE_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst4),
        .bus        (bus4),
        .retire_cnt (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one instruction on the M inputs; after return it sits in write-back.
    task automatic step(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] d);
        bus.M_instr  = i;
        bus.M_pc     = p;
        bus.M_alu    = a;
        bus.M_rdata  = d;
        bus4.M_instr = i;
        bus4.M_pc    = p;
        bus4.M_alu   = a;
        bus4.M_rdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string tag, input logic we,
                              input logic [4:0] addr, input logic [31:0] data);
        check({tag, "_we"},   32'(bus.ID_we), 32'(we));
        check({tag, "_addr"}, 32'(bus.ID_addr), 32'(addr));
        check({tag, "_data"}, bus.ID_data, data);
    endtask

    localparam logic [31:0] RD = 32'h80FF7F01;

    logic [31:0] cnt_seq [13];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        rst4 = 1'b0;
        bus.M_instr = '0; bus.M_pc = '0; bus.M_alu = '0; bus.M_rdata = '0;
        bus4.M_instr = '0; bus4.M_pc = '0; bus4.M_alu = '0; bus4.M_rdata = '0;

        // Reset state
        step(32'h24070009, 32'h100, 32'h9, '0);
        step(32'h24070009, 32'h104, 32'h9, '0);
        check_port("rst", 1'b0, 5'd0, 32'h0);
        check("rst_pc", bus.WB_pc_ID, 32'h0);
        check("rst_instr", bus.W_instr, 32'h0);
        check("rst_cnt", cnt, 32'h0);

        rst = 1'b1;
        step(32'h0, 32'h0, 32'h0, 32'h0);
        step(32'h0, 32'h0, 32'h0, 32'h0);
        check("rel_cnt_bubbles", cnt, 32'h0);
        step(32'h24070009, 32'h200, 32'h9, '0);
        check_port("rel_addiu", 1'b1, 5'd7, 32'h9);
        check("rel_cnt_inW", cnt, 32'h0);

        // Asynchronous reset mid-cycle with addiu in write-back
        #2 rst = 1'b0;
        #1;
        check_port("mid_rst", 1'b0, 5'd0, 32'h0);
        check("mid_rst_pc", bus.WB_pc_ID, 32'h0);
        check("mid_rst_instr", bus.W_instr, 32'h0);
        @(posedge clk);
        #1;
        check("mid_rst_cnt", cnt, 32'h0);
        rst = 1'b1;
        step(32'h24070009, 32'h204, 32'h9, '0);
        check_port("after_rst", 1'b1, 5'd7, 32'h9);
        check("after_rst_pc", bus.WB_pc_ID, 32'h204);
        check("after_rst_cnt", cnt, 32'h0);
        step(32'h0, 32'h0, 32'h0, 32'h0);
        check("after_rst_cnt1", cnt, 32'h1);

        // R-type, I-type, jal
        step(32'h00221821, 32'h1000, 32'h12345678, '0);
        check_port("addu", 1'b1, 5'd3, 32'h12345678);
        check("addu_instr", bus.W_instr, 32'h00221821);
        step(32'h34050042, 32'h1004, 32'h00000042, '0);
        check_port("ori", 1'b1, 5'd5, 32'h00000042);
        step(32'h0C000C00, 32'h00003000, 32'hDEADBEEF, '0);
        check_port("jal", 1'b1, 5'd31, 32'h00003008);
        step(32'h0C000C00, 32'hFFFFFFFC, 32'h0, '0);
        check_port("jal_wrap", 1'b1, 5'd31, 32'h00000004);

        // Loads with rdata 0x80FF7F01
        step(32'h80240000, 32'h1010, 32'h00002000, RD);
        check_port("lb0", 1'b1, 5'd4, 32'h00000001);
        step(32'h80240000, 32'h1014, 32'h00002001, RD);
        check_port("lb1", 1'b1, 5'd4, 32'h0000007F);
        step(32'h80240000, 32'h1018, 32'h00002002, RD);
        check_port("lb2", 1'b1, 5'd4, 32'hFFFFFFFF);
        step(32'h90240000, 32'h101C, 32'h00002003, RD);
        check_port("lbu3", 1'b1, 5'd4, 32'h00000080);
        step(32'h84240000, 32'h1020, 32'h00002002, RD);
        check_port("lh2", 1'b1, 5'd4, 32'hFFFF80FF);
        step(32'h84240000, 32'h1024, 32'h00002003, RD);
        check_port("lh3", 1'b1, 5'd4, 32'hFFFF80FF);
        step(32'h94240000, 32'h1028, 32'h00002000, RD);
        check_port("lhu0", 1'b1, 5'd4, 32'h00007F01);
        step(32'h8C240000, 32'h102C, 32'h00002003, RD);
        check_port("lw", 1'b1, 5'd4, 32'h80FF7F01);

        // No-write cases
        step(32'hAC240000, 32'h1100, 32'h2000, RD);
        check_port("sw", 1'b0, 5'd0, 32'h0);
        check("sw_pc", bus.WB_pc_ID, 32'h1100);
        step(32'h10220003, 32'h1104, 32'h55, '0);
        check_port("beq", 1'b0, 5'd0, 32'h0);
        check("beq_pc", bus.WB_pc_ID, 32'h1104);
        step(32'h03E01808, 32'h1108, 32'h77, '0);
        check_port("jr", 1'b0, 5'd0, 32'h0);
        check("jr_pc", bus.WB_pc_ID, 32'h1108);
        step(32'h0, 32'h0, 32'h99, '0);
        check_port("bubble", 1'b0, 5'd0, 32'h0);
        check("bubble_pc", bus.WB_pc_ID, 32'h0);
        step(32'h24200005, 32'h1110, 32'h5, '0);
        check_port("addiu0", 1'b0, 5'd0, 32'h0);
        check("addiu0_pc", bus.WB_pc_ID, 32'h1110);

        // Back-to-back writes to $2
        step(32'h24020001, 32'h1200, 32'h1, '0);
        check_port("b2b_1", 1'b1, 5'd2, 32'h1);
        step(32'h24020002, 32'h1204, 32'h2, '0);
        check_port("b2b_2", 1'b1, 5'd2, 32'h2);
        step(32'h0, 32'h0, 32'h0, '0);
        check_port("b2b_end", 1'b0, 5'd0, 32'h0);

        // Counter: 10 instructions interleaved with 3 bubbles
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        check("cnt_cleared", cnt, 32'h0);
        cnt_seq = '{32'h24020001, 32'h00221821, 32'h0, 32'hAC240000,
                    32'h10220003, 32'h34050042, 32'h0, 32'h8C240000,
                    32'h03E00008, 32'h0, 32'h24200005, 32'h0C000C00,
                    32'h24070009};
        for (int i = 0; i < 13; i++) begin
            step(cnt_seq[i], 32'h2000 + 32'(4 * i), 32'h0, '0);
            if (i == 3)
                check("cnt_partial", cnt, 32'h2);
        end
        step(32'h0, 32'h0, 32'h0, '0);
        check("cnt_ten", cnt, 32'd10);

        // 4-bit counter wrap
        rst4 = 1'b1;
        for (int i = 0; i < 16; i++)
            step(32'h24020001, 32'h3000 + 32'(4 * i), 32'h1, '0);
        check("cnt4_fifteen", 32'(cnt4), 32'd15);
        step(32'h0, 32'h0, 32'h0, '0);
        check("cnt4_wrap", 32'(cnt4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
